// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state type, the BCD digit geometry and a helper that
// sizes the digit count for a given binary width.
package bcd_pkg;

    // Converter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits per packed BCD digit
    localparam int unsigned BCD_DIGIT_W = 4;

    // Nibbles at or above this value are corrected by +3 before each shift
    localparam int unsigned ADD3_THRESH = 5;

    // Smallest number of decimal digits able to hold 2^width - 1.
    // The loop bound covers any width up to 63 bits.
    function automatic int unsigned min_digits(input int unsigned width);
        longint unsigned maxv;
        int unsigned     d;
        maxv = (width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
        d    = 1;
        for (int i = 0; i < 20; i++) begin
            if (maxv >= 64'd10) begin
                maxv = maxv / 64'd10;
                d    = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: one BCD nibble, "if >= 5 then add 3".
// Purely combinational. The sum is kept to 4 bits on purpose: inputs are
// never above 9 here, so the largest result is 12 and no carry exists.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    // Conditional +3 so the following left shift produces a valid decimal carry
    always_comb begin
        if (din >= BCD_DIGIT_W'(ADD3_THRESH)) begin
            dout = din + BCD_DIGIT_W'(3);
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin10_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready input.
// One value is accepted in IDLE, shifted WIDTH times in SHIFT, and the
// packed BCD result is published in a single step on the SHIFT->DONE edge
// so downstream 7-segment decoders never see a partial conversion.
// Optional feature macro: LEADING_ZERO_BLANK_EN adds a registered
// blank_mask output flagging leading-zero digits (digit 0 never blanked).
module bin10_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_bin,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          done,
    output logic                          busy
`ifdef LEADING_ZERO_BLANK_EN
    ,
    output logic [DIGITS-1:0]             blank_mask
`endif
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Reject digit counts too small to represent the largest input
    if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
        $error("DIGITS too small for WIDTH");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;

    logic [BCD_W-1:0]   work_adj;
    logic [BCD_W-1:0]   work_shift;
    logic               last_shift;
    // The top bit of the corrected work register is shifted out; it is
    // always zero when DIGITS is large enough.
    logic               unused_work_msb;

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0]  mask_q, mask_d;
    logic [DIGITS-1:0]  mask_new;
`endif

    // Per-digit +3 correction applied to the whole work register in parallel
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (work_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (work_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Corrected work register shifted left, taking in the next binary MSB
    always_comb begin
        work_shift = {work_adj[BCD_W-2:0], bin_q[WIDTH-1]};
        last_shift = (cnt_q == CNT_W'(WIDTH - 1));
    end

    assign unused_work_msb = work_adj[BCD_W-1];

`ifdef LEADING_ZERO_BLANK_EN
    // Blank digit i when it and every higher digit of the new result is zero
    always_comb begin
        logic zero_run;
        mask_new = '0;
        zero_run = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            zero_run    = zero_run && (work_shift[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            mask_new[i] = zero_run;
        end
    end
`endif

    // Next-state logic: accept in IDLE, one correct-and-shift per SHIFT cycle
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
`ifdef LEADING_ZERO_BLANK_EN
        mask_d  = mask_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = in_bin;
                    work_d  = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bin_d  = bin_q << 1;
                work_d = work_shift;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_shift) begin
                    // Publish the fully shifted value, not the pre-shift work register
                    bcd_d   = work_shift;
`ifdef LEADING_ZERO_BLANK_EN
                    mask_d  = mask_new;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
`ifdef LEADING_ZERO_BLANK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
`ifdef LEADING_ZERO_BLANK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    // Status outputs are plain decodes of the state register
    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q == SHIFT);
        done     = (state_q == DONE);
        bcd_out  = bcd_q;
`ifdef LEADING_ZERO_BLANK_EN
        blank_mask = mask_q;
`endif
    end

endmodule

// File: tb/tb_bin10_to_bcd_seq.sv
// Self-checking bench for bin10_to_bcd_seq: fixed vector table, hand-written
// handshake/reset sequences and a shuffled sweep of every 10-bit input
// against a decimal-arithmetic reference.
module tb_bin10_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_bin;
    logic [15:0] bcd_out;
    logic        done;
    logic        busy;
`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0]  blank_mask;
`endif

    int tests;
    int fails;

    bin10_to_bcd_seq #(
        .WIDTH  (10),
        .DIGITS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bin     (in_bin),
        .bcd_out    (bcd_out),
        .done       (done),
        .busy       (busy)
`ifdef LEADING_ZERO_BLANK_EN
        ,
        .blank_mask (blank_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by plain division
    function automatic logic [15:0] ref_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Reference: digit i is a leading zero exactly when v < 10^i (i >= 1)
    function automatic logic [3:0] ref_mask(input int v);
        logic [3:0] m;
        m = '0;
        if (v < 10)   m[1] = 1'b1;
        if (v < 100)  m[2] = 1'b1;
        if (v < 1000) m[3] = 1'b1;
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Offer v, wait for acceptance, then run until done or the cycle budget.
    // Called and returns at a falling edge.
    task automatic convert(input logic [9:0] v, output int lat, output int busy_n);
        int guard;
        in_bin   = v;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        busy_n   = 0;
        while (!done && lat < 40) begin
            busy_n += int'(busy);
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [9:0]  bin;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_mask;
    } vec_t;

    initial begin
        vec_t        vecs[10];
        int          lat;
        int          busy_n;
        int          nacc;
        int          acc_cyc[2];
        logic [15:0] res_q[$];
        logic [3:0]  msk_q[$];
        logic [15:0] prev;
        int          done_seen;
        int          guard;
        int          perm[1024];
        int          tmp;
        int          j;

        tests = 0;
        fails = 0;

        vecs[0] = '{10'd0,    16'h0000, 4'b1110};
        vecs[1] = '{10'd1,    16'h0001, 4'b1110};
        vecs[2] = '{10'd9,    16'h0009, 4'b1110};
        vecs[3] = '{10'd10,   16'h0010, 4'b1100};
        vecs[4] = '{10'd99,   16'h0099, 4'b1100};
        vecs[5] = '{10'd100,  16'h0100, 4'b1000};
        vecs[6] = '{10'd512,  16'h0512, 4'b1000};
        vecs[7] = '{10'd999,  16'h0999, 4'b1000};
        vecs[8] = '{10'd1000, 16'h1000, 4'b0000};
        vecs[9] = '{10'd1023, 16'h1023, 4'b0000};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_bin   = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset bcd_out",  32'(bcd_out),  32'h0);
        check("reset done",     32'(done),     32'd0);
        check("reset busy",     32'(busy),     32'd0);
`ifdef LEADING_ZERO_BLANK_EN
        check("reset blank_mask", 32'(blank_mask), 32'h0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Max value: latency, busy length, one-cycle done
        convert(10'd1023, lat, busy_n);
        check("1023 done seen",   32'(done),    32'd1);
        check("1023 latency",     32'(lat),     32'd11);
        check("1023 busy cycles", 32'(busy_n),  32'd10);
        check("1023 bcd_out",     32'(bcd_out), 32'h1023);
        check("1023 in_ready in DONE", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("1023 done one cycle",   32'(done),     32'd0);
        check("1023 in_ready back",    32'(in_ready), 32'd1);
        check("1023 bcd_out held",     32'(bcd_out),  32'h1023);

        // Fixed table
        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].bin, lat, busy_n);
            check($sformatf("vec %0d done", vecs[i].bin), 32'(done), 32'd1);
            check($sformatf("vec %0d bcd", vecs[i].bin), 32'(bcd_out), 32'(vecs[i].exp_bcd));
`ifdef LEADING_ZERO_BLANK_EN
            check($sformatf("vec %0d mask", vecs[i].bin), 32'(blank_mask),
                  32'(vecs[i].exp_mask));
`endif
        end

        // Back-to-back 7 then 500 with in_valid held high
        @(negedge clk);
        @(negedge clk);
        in_bin   = 10'd7;
        in_valid = 1'b1;
        nacc     = 0;
        acc_cyc  = '{-1, -1};
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (in_valid && in_ready && nacc < 2) begin
                acc_cyc[nacc] = cyc;
                nacc++;
            end
            @(negedge clk);
            if (done) begin
                res_q.push_back(bcd_out);
`ifdef LEADING_ZERO_BLANK_EN
                msk_q.push_back(blank_mask);
`endif
            end
            if (nacc == 1 && !in_ready) in_bin = 10'd500;
            if (nacc == 2 && !in_ready) in_valid = 1'b0;
        end
        check("b2b accepts",  32'(nacc), 32'd2);
        check("b2b spacing",  32'(acc_cyc[1] - acc_cyc[0]), 32'd12);
        check("b2b results",  32'(res_q.size()), 32'd2);
        check("b2b res0", (res_q.size() > 0) ? 32'(res_q[0]) : 32'hxxxx_xxxx, 32'h0007);
        check("b2b res1", (res_q.size() > 1) ? 32'(res_q[1]) : 32'hxxxx_xxxx, 32'h0500);
`ifdef LEADING_ZERO_BLANK_EN
        check("b2b mask0", (msk_q.size() > 0) ? 32'(msk_q[0]) : 32'hxxxx_xxxx, 32'b1110);
        check("b2b mask1", (msk_q.size() > 1) ? 32'(msk_q[1]) : 32'hxxxx_xxxx, 32'b1000);
`endif

        // 999 accepted, in_bin changed with in_valid held during SHIFT
        prev     = bcd_out;
        in_bin   = 10'd999;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_bin = 10'd5;
        repeat (4) @(negedge clk);
        check("999 busy mid",       32'(busy),     32'd1);
        check("999 in_ready mid",   32'(in_ready), 32'd0);
        check("999 bcd_out held",   32'(bcd_out),  32'(prev));
        guard = 0;
        while (!done && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        check("999 done seen", 32'(done),    32'd1);
        check("999 bcd_out",   32'(bcd_out), 32'h0999);
        @(negedge clk);
        @(negedge clk);
        check("999 no late accept", 32'(busy), 32'd0);

        // Reset in the middle of converting 512
        in_bin   = 10'd512;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst bcd_out",  32'(bcd_out),  32'h0);
        check("midrst busy",     32'(busy),     32'd0);
        done_seen = int'(done);
        repeat (3) begin
            @(negedge clk);
            done_seen += int'(done);
        end
        check("midrst in_ready held", 32'(in_ready), 32'd1);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            done_seen += int'(done);
        end
        check("midrst no done",       32'(done_seen), 32'd0);
        check("midrst bcd_out after", 32'(bcd_out),   32'h0);
        convert(10'd512, lat, busy_n);
        check("post-rst 512 done", 32'(done),    32'd1);
        check("post-rst 512 bcd",  32'(bcd_out), 32'h0512);

        // Shuffled sweep of every input value
        for (int i = 0; i < 1024; i++) perm[i] = i;
        for (int i = 1023; i > 0; i--) begin
            j       = int'($urandom_range(i, 0));
            tmp     = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        for (int i = 0; i < 1024; i++) begin
            convert(10'(perm[i]), lat, busy_n);
            check($sformatf("sweep %0d", perm[i]), {15'd0, done, bcd_out},
                  {15'd0, 1'b1, ref_bcd(perm[i])});
`ifdef LEADING_ZERO_BLANK_EN
            check($sformatf("sweep mask %0d", perm[i]), 32'(blank_mask),
                  32'(ref_mask(perm[i])));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bin10_to_bcd_seq.md
Name: bin10_to_bcd_seq

Overview:
Sequential double-dabble (shift-and-add-3) converter that turns a 10-bit binary value into four packed BCD digits. It sits directly upstream of the per-digit 7-segment decoders, and each output nibble drives one decoder's 4-bit input. A valid/ready handshake accepts a value, and the result is held stable until the next conversion completes, so the display never shows partial results.

Parameters:
WIDTH, 10, binary input width in bits; sets the shift count.
DIGITS, 4, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream presents a value on in_bin.
in_ready  output  1  converter idle; a value is accepted when in_valid && in_ready at a rising edge.
in_bin  input  WIDTH  binary value to convert.
bcd_out  output  4*DIGITS  registered BCD result; [3:0] = ones, [7:4] = tens, [11:8] = hundreds, [15:12] = thousands.
done  output  1  one-cycle pulse: bcd_out has just been updated.
busy  output  1  conversion in progress (state SHIFT).

Behaviour:
- Reset (async, active-high): state=IDLE, bcd_out=0, done=0, busy=0, shift count=0, working registers=0. in_ready=1 while in reset, since it decodes IDLE.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid at edge E0: load in_bin into the binary shift register, clear the BCD work register, count=0, go to SHIFT.
- SHIFT: in_ready=0, busy=1. Each cycle:
  - Every BCD work nibble >= 5 gets +3. This is combinational and done on all nibbles in parallel.
  - Then shift {bcd_work, bin_shift} left by 1.
  - count++.
  - After the WIDTH-th shift (count == WIDTH-1 at the edge), copy bcd_work into bcd_out and go to DONE.
- DONE: done=1 for exactly one cycle, in_ready=0. Next edge returns to IDLE.
- Latency: accept at E0, bcd_out valid after E10, done high between E10 and E11, in_ready high again after E11. Throughput is one conversion per 12 cycles.
- bcd_out changes only at the SHIFT→DONE edge and holds its value in IDLE, in SHIFT and after reset.
- in_valid while not in IDLE is ignored. No value is captured or queued, and upstream must hold in_valid until accepted.
- in_bin is sampled only at the accept edge; later changes have no effect on the conversion in flight.
- Width rules:
  - Add-3 is 4-bit with no carry out: nibble <= 9 after a shift is guaranteed because the correction happens before the shift.
  - Maximum input 1023 → 1,0,2,3. No overflow is possible under the DIGITS rule.
- Reset mid-conversion aborts immediately: bcd_out=0, done never pulses, state=IDLE.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: adds output blank_mask [DIGITS-1:0], registered alongside bcd_out.
  - Bit i = 1 when digit i and all higher digits are zero.
  - Bit 0 is forced to 0, so a value of 0 shows a single "0".
  - Reset value 0.
  - Downstream uses the mask to drive the segments dark.
- Not defined: the port is absent and all digits are always shown, including leading zeros.

Decomposition:
- Package bcd_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - BCD_DIGIT_W=4;
  - ADD3_THRESH=5;
  - function computing the minimum DIGITS for a given WIDTH, used by an elaboration check.
- Sub-module bcd_add3: 4-bit combinational "if >=5 add 3" cell, instantiated DIGITS times via generate.

Test Plan:
- Reset, then in_bin=1023 with in_valid pulse → done after 11 edges; bcd_out=16'h1023; busy high for exactly 10 cycles.
- in_bin=0 → bcd_out=16'h0000. With LEADING_ZERO_BLANK_EN: blank_mask=4'b1110.
- in_bin=7, then in_bin=500 back-to-back with in_valid held high:
  - second value accepted only after in_ready returns (12-cycle spacing);
  - results 16'h0007, then 16'h0500; with blank mask 4'b1110, then 4'b1000.
- in_bin=999 accepted; change in_bin to 5 and hold in_valid during SHIFT → result 16'h0999; busy-period valid is ignored.
- Start conversion of 512; assert rst at cycle 5 → bcd_out=0, no done pulse, in_ready=1 during reset. After release, convert 512 → 16'h0512.
- Random sweep of all 1024 inputs compared against a reference model of value/1000, (value/100)%10, (value/10)%10 and value%10 → zero mismatches.
